// File: rtl/ram_boot_loader_pkg.sv
// Shared types and constants for the RAM boot loader: FSM states and frame geometry.
package ram_boot_loader_pkg;

   typedef enum logic [2:0] {
      S_HDR0  = 3'd0,
      S_HDR1  = 3'd1,
      S_WORD  = 3'd2,
      S_WRITE = 3'd3,
      S_CHK   = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_e;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int CHK_W      = 8;

endpackage

// File: rtl/ram_boot_loader.sv
// Boot loader: holds the CPU in reset, streams a framed image into block RAM,
// verifies an XOR checksum, then hands the RAM write port to the CPU.
module ram_boot_loader
   import ram_boot_loader_pkg::*;
#(
   parameter int SIZE      = 14,
   parameter int DEPTH     = 1024,
   parameter int BASE_ADDR = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      i_byte,
   input  logic            i_byte_valid,
   output logic            o_byte_ready,
   output logic            o_cpu_rst,
   output logic            o_done,
   output logic            o_error,
   input  logic            cpu_wrEn,
   input  logic [SIZE-1:0] cpu_addr,
   input  logic [31:0]     cpu_data,
   output logic            ram_wrEn,
   output logic [SIZE-1:0] ram_addr,
   output logic [31:0]     ram_data,
   output state_e          o_state
);

   localparam logic [31:0] N_LIMIT = 32'(DEPTH - BASE_ADDR);

   // Handshake: a byte transfers on a rising clk edge where i_byte_valid && o_byte_ready.
   state_e             state_q, state_d;
   logic [15:0]        n_q, n_d;
   logic [15:0]        k_q, k_d;
   logic [1:0]         idx_q, idx_d;
   logic [31:0]        word_q, word_d;
   logic [CHK_W-1:0]   xor_q, xor_d;
   logic               done_q, error_q, cpu_rst_q;
   logic               byte_ready;
   logic               take;
   logic [15:0]        n_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_HDR0;
         n_q       <= '0;
         k_q       <= '0;
         idx_q     <= '0;
         word_q    <= '0;
         xor_q     <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         cpu_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         k_q       <= k_d;
         idx_q     <= idx_d;
         word_q    <= word_d;
         xor_q     <= xor_d;
         done_q    <= (state_d == S_DONE);
         error_q   <= (state_d == S_ERROR);
         cpu_rst_q <= (state_d != S_DONE);
      end
   end

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      k_d        = k_q;
      idx_d      = idx_q;
      word_d     = word_q;
      xor_d      = xor_q;
      byte_ready = !rst && ((state_q == S_HDR0) || (state_q == S_HDR1) ||
                            (state_q == S_WORD) || (state_q == S_CHK));
      take       = i_byte_valid && byte_ready;
      n_full     = {n_q[15:8], i_byte};

      case (state_q)
         S_HDR0: begin
            if (take) begin
               n_d[15:8] = i_byte;
               xor_d     = xor_q ^ i_byte;
               state_d   = S_HDR1;
            end
         end
         S_HDR1: begin
            if (take) begin
               n_d[7:0] = i_byte;
               xor_d    = xor_q ^ i_byte;
               if ({16'd0, n_full} > N_LIMIT)
                  state_d = S_ERROR;
               else if (n_full == 16'd0)
                  state_d = S_CHK;
               else
                  state_d = S_WORD;
            end
         end
         S_WORD: begin
            // First byte of a word ends up in [7:0] after four right shifts.
            if (take) begin
               word_d = {i_byte, word_q[31:8]};
               xor_d  = xor_q ^ i_byte;
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'(WORD_BYTES - 1))
                  state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            k_d     = k_q + 16'd1;
            state_d = ((k_q + 16'd1) < n_q) ? S_WORD : S_CHK;
         end
         S_CHK: begin
            if (take)
               state_d = (i_byte == xor_q) ? S_DONE : S_ERROR;
         end
         default: ;
      endcase
   end

   assign o_byte_ready = byte_ready;
   assign o_cpu_rst    = cpu_rst_q;
   assign o_done       = done_q;
   assign o_error      = error_q;
   assign o_state      = state_q;

   // After a good load the CPU owns the RAM write port with no added latency.
   assign ram_wrEn = (state_q == S_DONE) ? cpu_wrEn : (state_q == S_WRITE);
   assign ram_addr = (state_q == S_DONE)  ? cpu_addr :
                     (state_q == S_WRITE) ? (SIZE'(BASE_ADDR) + SIZE'(k_q)) : '0;
   assign ram_data = (state_q == S_DONE)  ? cpu_data :
                     (state_q == S_WRITE) ? word_q : '0;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Self-checking bench for ram_boot_loader: frame loads, checksum errors,
// oversize rejection, backpressure, mid-frame reset and CPU pass-through.
module tb_ram_boot_loader;
   import ram_boot_loader_pkg::*;

   localparam int SIZE      = 14;
   localparam int DEPTH     = 1024;
   localparam int BASE_ADDR = 0;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      i_byte;
   logic            i_byte_valid;
   logic            o_byte_ready, o_cpu_rst, o_done, o_error;
   logic            cpu_wrEn;
   logic [SIZE-1:0] cpu_addr;
   logic [31:0]     cpu_data;
   logic            ram_wrEn;
   logic [SIZE-1:0] ram_addr;
   logic [31:0]     ram_data;
   state_e          dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [SIZE+31:0] exp_q[$];
   logic [7:0]       frame_q[$];
   logic [31:0]      words[4];
   logic [31:0]      mem [0:(1<<SIZE)-1];
   logic             pre_cpu_rst;

   ram_boot_loader #(.SIZE(SIZE), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
      .clk(clk), .rst(rst),
      .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
      .o_cpu_rst(o_cpu_rst), .o_done(o_done), .o_error(o_error),
      .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_data(ram_data),
      .o_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      i_byte_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
   endtask

   // ---------------- block RAM model + write scoreboard ----------------
   always @(posedge clk) if (ram_wrEn) mem[ram_addr] <= ram_data;

   always @(negedge clk) begin
      if (!rst && ram_wrEn) begin
         logic [SIZE+31:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL ram_write: unexpected write addr=%0d data=%h", ram_addr, ram_data);
         end else begin
            e = exp_q.pop_front();
            if ({ram_addr, ram_data} !== e) begin
               failures++;
               $display("FAIL ram_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                        ram_addr, ram_data, e[SIZE+31:32], e[31:0]);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   // Called at posedge+1; returns at posedge+1 after the byte transferred.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      bit r;
      ok = 1'b0;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
      i_byte = b;
      i_byte_valid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         r = o_byte_ready;
         @(posedge clk);
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      #1 i_byte_valid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_byte: byte %h not accepted within 200 cycles", b);
      end
   endtask

   task automatic make_frame(input int n, input bit bad);
      logic [7:0] x;
      logic [15:0] n16;
      n16 = 16'(n);
      frame_q.delete();
      frame_q.push_back(n16[15:8]);
      frame_q.push_back(n16[7:0]);
      x = n16[15:8] ^ n16[7:0];
      for (int k = 0; k < n; k++) begin
         for (int b = 0; b < 4; b++) begin
            frame_q.push_back(words[k][8*b +: 8]);
            x = x ^ words[k][8*b +: 8];
         end
         exp_q.push_back({SIZE'(BASE_ADDR + k), words[k]});
      end
      frame_q.push_back(bad ? (x ^ 8'h01) : x);
   endtask

   task automatic send_frame(input int gap_max);
      int nb;
      bit after_write;
      nb = frame_q.size();
      after_write = 1'b0;
      for (int i = 0; i < nb; i++) begin
         if (i == nb - 1) pre_cpu_rst = o_cpu_rst;
         send_byte(frame_q[i], after_write ? 0 : int'($urandom_range(0, gap_max)));
         after_write = 1'b0;
         if (i >= 2 && i < nb - 1 && ((i - 2) % 4) == 3) begin
            after_write = 1'b1;
            checks++;
            if (ram_wrEn !== 1'b1 || o_byte_ready !== 1'b0) begin
               failures++;
               $display("FAIL write_timing: byte %0d wrEn=%b ready=%b, expected wrEn=1 ready=0",
                        i, ram_wrEn, o_byte_ready);
            end
         end
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s: %0d expected writes missing", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(posedge clk); #1 rst = 1'b1;
      #1;
      checks++;
      if ({o_byte_ready, o_cpu_rst, o_done, o_error, ram_wrEn} !== 5'b01000 ||
          ram_addr !== '0 || ram_data !== '0) begin
         failures++;
         $display("FAIL reset_outputs: ready=%b cpu_rst=%b done=%b err=%b wr=%b addr=%0d data=%h, expected 0 1 0 0 0 0 0",
                  o_byte_ready, o_cpu_rst, o_done, o_error, ram_wrEn, ram_addr, ram_data);
      end
      @(posedge clk); #1 rst = 1'b0;
      #1;
      checks++;
      if (dbg_state !== S_HDR0 || o_byte_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release: state=%0d ready=%b, expected state=0 ready=1", dbg_state, o_byte_ready);
      end
      exp_q.delete();
   endtask

   task automatic check_two_word_load(input string name);
      checks++;
      if (pre_cpu_rst !== 1'b1 || o_cpu_rst !== 1'b0 || o_done !== 1'b1 || o_error !== 1'b0) begin
         failures++;
         $display("FAIL %s_done: cpu_rst before=%b after=%b done=%b err=%b, expected 1 0 1 0",
                  name, pre_cpu_rst, o_cpu_rst, o_done, o_error);
      end
      checks++;
      if (mem[0] !== 32'h11223344 || mem[1] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL %s_ram: RAM[0]=%h RAM[1]=%h, expected 11223344 deadbeef", name, mem[0], mem[1]);
      end
      check_drained(name);
   endtask

   task automatic test_two_word();
      do_reset();
      mem[0] = '0;
      mem[1] = '0;
      words[0] = 32'h11223344;
      words[1] = 32'hDEADBEEF;
      make_frame(2, 1'b0);
      send_frame(0);
      check_two_word_load("two_word");
   endtask

   task automatic test_bad_checksum();
      do_reset();
      words[0] = 32'h11223344;
      words[1] = 32'hDEADBEEF;
      make_frame(2, 1'b1);
      send_frame(0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (o_error !== 1'b1 || o_done !== 1'b0 || o_cpu_rst !== 1'b1 || o_byte_ready !== 1'b0) begin
         failures++;
         $display("FAIL bad_checksum: err=%b done=%b cpu_rst=%b ready=%b, expected 1 0 1 0",
                  o_error, o_done, o_cpu_rst, o_byte_ready);
      end
      check_drained("bad_checksum");
   endtask

   task automatic test_zero_length();
      do_reset();
      make_frame(0, 1'b0);
      send_frame(0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (o_done !== 1'b1 || o_cpu_rst !== 1'b0 || o_error !== 1'b0 || dbg_state !== S_DONE) begin
         failures++;
         $display("FAIL zero_length: done=%b cpu_rst=%b err=%b state=%0d, expected 1 0 0 5",
                  o_done, o_cpu_rst, o_error, dbg_state);
      end
      check_drained("zero_length");
   endtask

   task automatic test_oversize();
      do_reset();
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      checks++;
      if (o_error !== 1'b1 || dbg_state !== S_ERROR || o_byte_ready !== 1'b0) begin
         failures++;
         $display("FAIL oversize_error: err=%b state=%0d ready=%b, expected 1 6 0",
                  o_error, dbg_state, o_byte_ready);
      end
      i_byte = 8'hAA;
      i_byte_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (o_byte_ready !== 1'b0 || o_cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL oversize_hold: ready=%b cpu_rst=%b, expected 0 1", o_byte_ready, o_cpu_rst);
         end
      end
      @(posedge clk); #1 i_byte_valid = 1'b0;
      check_drained("oversize");
   endtask

   task automatic test_backpressure();
      do_reset();
      mem[0] = '0;
      mem[1] = '0;
      words[0] = 32'h11223344;
      words[1] = 32'hDEADBEEF;
      make_frame(2, 1'b0);
      send_frame(3);
      check_two_word_load("backpressure");
   endtask

   task automatic test_reset_passthrough();
      do_reset();
      words[0] = 32'h11223344;
      words[1] = 32'hDEADBEEF;
      make_frame(2, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(frame_q[i], 0);
      exp_q.delete();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (o_byte_ready !== 1'b0 || o_cpu_rst !== 1'b1 || dbg_state !== S_HDR0) begin
         failures++;
         $display("FAIL midframe_reset: ready=%b cpu_rst=%b state=%0d, expected 0 1 0",
                  o_byte_ready, o_cpu_rst, dbg_state);
      end
      @(posedge clk); #1 rst = 1'b0;
      words[0] = 32'hA5A55A5A;
      words[1] = 32'h0F1E2D3C;
      words[2] = 32'h12345678;
      make_frame(3, 1'b0);
      send_frame(1);
      checks++;
      if (o_done !== 1'b1 || o_cpu_rst !== 1'b0 ||
          mem[0] !== 32'hA5A55A5A || mem[1] !== 32'h0F1E2D3C || mem[2] !== 32'h12345678) begin
         failures++;
         $display("FAIL reload: done=%b cpu_rst=%b RAM0=%h RAM1=%h RAM2=%h, expected 1 0 a5a55a5a 0f1e2d3c 12345678",
                  o_done, o_cpu_rst, mem[0], mem[1], mem[2]);
      end
      check_drained("reload");
      cpu_wrEn = 1'b1;
      cpu_addr = SIZE'(50);
      cpu_data = 32'd7;
      exp_q.push_back({SIZE'(50), 32'd7});
      #1;
      checks++;
      if (ram_wrEn !== 1'b1 || ram_addr !== SIZE'(50) || ram_data !== 32'd7) begin
         failures++;
         $display("FAIL passthrough: wr=%b addr=%0d data=%0d, expected 1 50 7", ram_wrEn, ram_addr, ram_data);
      end
      @(posedge clk); #1;
      cpu_wrEn = 1'b0;
      cpu_addr = '0;
      cpu_data = '0;
      #1;
      checks++;
      if (mem[50] !== 32'd7 || ram_wrEn !== 1'b0) begin
         failures++;
         $display("FAIL passthrough_ram: RAM[50]=%0d wr=%b, expected 7 0", mem[50], ram_wrEn);
      end
      check_drained("passthrough");
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst          = 1'b1;
      i_byte       = '0;
      i_byte_valid = 1'b0;
      cpu_wrEn     = 1'b0;
      cpu_addr     = '0;
      cpu_data     = '0;
      pre_cpu_rst  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_two_word();
      test_bad_checksum();
      test_zero_length();
      test_oversize();
      test_backpressure();
      test_reset_passthrough();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
